reset_sequencer: RTL and testbench

//  Consumer side of the board clock/reset front end: takes the raw board clock and an

---
 rtl/reset_seq_pkg.sv | 7 +
 rtl/reset_sync.sv | 15 +
 rtl/reset_sequencer.sv | 100 ++++++++++
 tb/tb_reset_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state type and sizing helper for the reset sequencer.
package reset_seq_pkg;
  typedef enum logic [2:0] {SYNC, STRETCH, PERIPH, RUN, QUIESCE} rseq_state_t;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: async-assert / sync-deassert reset chain of STAGES flops.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_ni,
  output logic rst_no
);
  logic [STAGES-1:0] sync_q, sync_d;
  assign sync_d = (sync_q << 1) | STAGES'(1);
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else sync_q <= sync_d;
  assign rst_no = sync_q[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered periph/core reset release with soft-reset re-sequencing
// and a clock-enable tick divider.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SLOW           = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic ext_rst_req,
  output logic periph_resetn_o,
  output logic core_resetn_o,
  output logic ready_o,
  output logic tick_o
);
  localparam int CW = $clog2(max2(STRETCH_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] ST_LD  = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);

  rseq_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic          periph_q, core_q, ready_q, tick_q, sync_rst_n, wrap;

  // The state register leaving SYNC acts as the final synchroniser stage,
  // so the chain itself is one flop shorter than SYNC_STAGES.
  reset_sync #(.STAGES(SYNC_STAGES - 1)) u_sync (
    .clk    (clk),
    .rst_ni (resetn),
    .rst_no (sync_rst_n)
  );

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= SYNC;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        SYNC: if (sync_rst_n) begin
          state_q <= STRETCH;
          cnt_q   <= ST_LD;
        end
        STRETCH:
          if (ext_rst_req) cnt_q <= ST_LD;
          else if (cnt_q == '0) begin
            state_q  <= PERIPH;
            periph_q <= 1'b1;
            cnt_q    <= GAP_LD;
          end else cnt_q <= cnt_q - CW'(1);
        PERIPH:
          if (ext_rst_req) begin
            state_q  <= STRETCH;
            periph_q <= 1'b0;
            cnt_q    <= ST_LD;
          end else if (cnt_q == '0) begin
            state_q <= RUN;
            core_q  <= 1'b1;
            ready_q <= 1'b1;
          end else cnt_q <= cnt_q - CW'(1);
        RUN: if (ext_rst_req) begin
          state_q <= QUIESCE;
          core_q  <= 1'b0;
          ready_q <= 1'b0;
          cnt_q   <= GAP_LD;
        end
        QUIESCE:
          if (cnt_q == '0) begin
            state_q  <= STRETCH;
            periph_q <= 1'b0;
            cnt_q    <= ST_LD;
          end else cnt_q <= cnt_q - CW'(1);
        default: state_q <= SYNC;
      endcase
    end

  if (SLOW > 0) begin : g_div
    logic [SLOW-1:0] div_q, div_d;
    assign div_d = periph_q ? div_q + SLOW'(1) : '0;
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) div_q <= '0;
      else div_q <= div_d;
    assign wrap = &div_q;
  end else begin : g_nodiv
    assign wrap = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) tick_q <= 1'b0;
    else tick_q <= periph_q & wrap;

  assign periph_resetn_o = periph_q;
  assign core_resetn_o   = core_q;
  assign ready_o         = ready_q;
  assign tick_o          = tick_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table-driven check of the reset sequencer with default
// parameters (SLOW=2) and a SLOW=0 twin sharing the same stimulus.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic ext_rst_req = 1'b0;
  logic p2, c2, r2, t2, p0, c0, r0, t0;
  logic chk_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.SLOW(2)) dut (
    .clk(clk), .resetn(resetn), .ext_rst_req(ext_rst_req),
    .periph_resetn_o(p2), .core_resetn_o(c2), .ready_o(r2), .tick_o(t2)
  );

  reset_sequencer #(.SLOW(0)) dut0 (
    .clk(clk), .resetn(resetn), .ext_rst_req(ext_rst_req),
    .periph_resetn_o(p0), .core_resetn_o(c0), .ready_o(r0), .tick_o(t0)
  );

  typedef struct packed {
    logic [7:0] n;
    logic       ext, p, c, r;
  } vec_t;
  localparam int NV = 21;
  vec_t tbl [0:NV-1];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("inv_core_periph", {3'b0, c2 & ~p2}, 4'b0);
    chk("inv_core_periph0", {3'b0, c0 & ~p0}, 4'b0);
    chk("inv_ready_state", {3'b0, r2}, {3'b0, dut.state_q == RUN});
  end

  initial begin
    // {edges, ext_rst_req, periph, core, ready}, each row checked on every edge
    tbl = '{
      '{8'd17, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'd4,  1'b0, 1'b1, 1'b0, 1'b0},
      '{8'd9,  1'b0, 1'b1, 1'b1, 1'b1},
      '{8'd1,  1'b1, 1'b1, 1'b0, 1'b0},
      '{8'd3,  1'b0, 1'b1, 1'b0, 1'b0},
      '{8'd16, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'd4,  1'b0, 1'b1, 1'b0, 1'b0},
      '{8'd3,  1'b0, 1'b1, 1'b1, 1'b1},
      '{8'd1,  1'b1, 1'b1, 1'b0, 1'b0},
      '{8'd3,  1'b0, 1'b1, 1'b0, 1'b0},
      '{8'd16, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'd2,  1'b0, 1'b1, 1'b0, 1'b0},
      '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0},
      '{8'd15, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'd4,  1'b0, 1'b1, 1'b0, 1'b0},
      '{8'd2,  1'b0, 1'b1, 1'b1, 1'b1},
      '{8'd4,  1'b1, 1'b1, 1'b0, 1'b0},
      '{8'd25, 1'b1, 1'b0, 1'b0, 1'b0},
      '{8'd15, 1'b0, 1'b0, 1'b0, 1'b0},
      '{8'd4,  1'b0, 1'b1, 1'b0, 1'b0},
      '{8'd2,  1'b0, 1'b1, 1'b1, 1'b1}
    };
    #1 resetn = 1'b0;
    chk_en = 1'b1;
    #11;
    chk("reset_state", {p2, c2, r2, t2}, 4'b0000);
    chk("reset_state0", {p0, c0, r0, t0}, 4'b0000);
    resetn = 1'b1;
    for (int i = 0; i < NV; i++)
      for (int k = 0; k < int'(tbl[i].n); k++) begin
        ext_rst_req = tbl[i].ext;
        @(posedge clk); #1;
        chk($sformatf("row%0d", i), {1'b0, p2, c2, r2}, {1'b0, tbl[i].p, tbl[i].c, tbl[i].r});
        chk($sformatf("row%0d_slow0", i), {1'b0, p0, c0, r0}, {1'b0, tbl[i].p, tbl[i].c, tbl[i].r});
      end
    ext_rst_req = 1'b0;
    // 3 ns async reset pulse between edges while in RUN
    #1 resetn = 1'b0;
    #1;
    chk("async_pulse", {p2, c2, r2, t2}, 4'b0000);
    chk("async_pulse0", {p0, c0, r0, t0}, 4'b0000);
    #2 resetn = 1'b1;
    // release at edge 18, core at 22; SLOW=2 ticks at 22,26,30; SLOW=0 tick from 19
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      chk($sformatf("rerun_e%0d", n), {p2, c2, r2, t2},
          {n >= 18, n >= 22, n >= 22, (n >= 22) && ((n - 22) % 4 == 0)});
      chk($sformatf("rerun0_e%0d", n), {p0, c0, r0, t0},
          {n >= 18, n >= 22, n >= 22, n >= 19});
    end
    for (int i = 0; i < 400; i++) begin
      ext_rst_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) begin
        #1 resetn = 1'b0;
        #2 resetn = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
